// File: rtl/flash_sample_reader.sv
// Fetches one byte-wide audio sample from word-addressed flash over Avalon-MM,
// keeping the last fetched word so repeated reads from the same word skip the bus.
module flash_sample_reader #(
  parameter bit SIGNED_SAMPLES = 1'b1,
  parameter bit HOLD_CACHE     = 1'b1
) (
  input  logic        fetch_clock,
  input  logic        reset,
  input  logic        start,
  input  logic [22:0] word_addr,
  input  logic [1:0]  byte_sel,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  output logic [3:0]  flash_mem_byteenable,
  input  logic        flash_mem_waitrequest,
  input  logic        flash_mem_readdatavalid,
  input  logic [31:0] flash_mem_readdata,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic [2:0]  debug_state
);

  // Handshakes: the flash read is accepted on a cycle with read=1 and
  // waitrequest=0; a sample transfers on a cycle with valid=1 and ready=1.
  // Both sides hold their payload stable until that cycle.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DATA = 3'd2,
    EXTRACT   = 3'd3,
    PRESENT   = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [22:0] addr_q;
  logic [1:0]  byte_q;
  logic [22:0] cache_addr;
  logic [31:0] cache_word;
  logic        cache_valid;
  logic        cache_hit;
  logic [7:0]  picked;
  logic [7:0]  sample_byte;

  assign cache_hit            = HOLD_CACHE && cache_valid && (word_addr == cache_addr);
  assign flash_mem_address    = addr_q;
  assign flash_mem_byteenable = 4'b1111;

  always_ff @(posedge fetch_clock) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      byte_q      <= '0;
      cache_addr  <= '0;
      cache_word  <= '0;
      cache_valid <= 1'b0;
      sample_data <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        addr_q <= word_addr;
        byte_q <= byte_sel;
      end
      // Data is only taken while a read is outstanding; stray beats are dropped.
      if (state == WAIT_DATA && flash_mem_readdatavalid) begin
        cache_word  <= flash_mem_readdata;
        cache_addr  <= addr_q;
        cache_valid <= 1'b1;
      end
      if (state == EXTRACT) begin
        sample_data <= {sample_byte, 8'h00};
      end
    end
  end

  always_comb begin
    picked = cache_word[7:0];
    case (byte_q)
      2'd0: picked = cache_word[7:0];
      2'd1: picked = cache_word[15:8];
      2'd2: picked = cache_word[23:16];
      2'd3: picked = cache_word[31:24];
      default: picked = cache_word[7:0];
    endcase
    // Offset-binary becomes two's complement by flipping the sign bit.
    sample_byte = SIGNED_SAMPLES ? picked : {~picked[7], picked[6:0]};
  end

  always_comb begin
    state_next     = state;
    flash_mem_read = 1'b0;
    sample_valid   = 1'b0;
    busy           = (state != IDLE);
    debug_state    = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = cache_hit ? EXTRACT : ISSUE;
        end
      end
      ISSUE: begin
        flash_mem_read = 1'b1;
        if (!flash_mem_waitrequest) begin
          state_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          state_next = EXTRACT;
        end
      end
      EXTRACT: begin
        state_next = PRESENT;
      end
      PRESENT: begin
        sample_valid = 1'b1;
        if (sample_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/flash_sample_reader.md
FLASH_SAMPLE_READER -- requirements
Module: flash_sample_reader

Interface
REQ-001 Parameter SIGNED_SAMPLES, default 1; 1 = flash bytes are two's-complement, 0 = offset-binary (MSB inverted on output).
REQ-002 Parameter HOLD_CACHE, default 1; 1 = reuse the last fetched word on an address hit, 0 = always read flash.
REQ-003 fetch_clock  in  1  clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse requesting the sample at word_addr/byte_sel.
REQ-006 word_addr  in  23  flash word address supplied by the upstream fetcher.
REQ-007 byte_sel  in  2  byte index within the word, supplied by the upstream fetcher.
REQ-008 flash_mem_read  out  1  Avalon-MM read strobe.
REQ-009 flash_mem_address  out  23  Avalon-MM word address.
REQ-010 flash_mem_byteenable  out  4  constant 4'b1111.
REQ-011 flash_mem_waitrequest  in  1  slave stall; read is accepted on a cycle with read=1 and waitrequest=0.
REQ-012 flash_mem_readdatavalid  in  1  qualifies flash_mem_readdata.
REQ-013 flash_mem_readdata  in  32  returned word.
REQ-014 sample_data  out  16  signed audio sample.
REQ-015 sample_valid  out  1  sample_data is valid.
REQ-016 sample_ready  in  1  consumer accepts; a transfer occurs when valid=1 and ready=1.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, ISSUE, WAIT_DATA, EXTRACT, PRESENT; the encoding is free.
REQ-019 IDLE: on start, latch word_addr and byte_sel. On a cache hit (HOLD_CACHE=1, cache_valid=1, word_addr equals cached address), go to EXTRACT. Otherwise go to ISSUE.
REQ-020 ISSUE: flash_mem_read=1 and flash_mem_address=latched address, both held stable while waitrequest=1. On acceptance, go to WAIT_DATA; read=0 from the next cycle.
REQ-021 WAIT_DATA: on readdatavalid=1, capture readdata into the word cache, store the address, set cache_valid=1, go to EXTRACT. There is no timeout.
REQ-022 readdatavalid is ignored in IDLE, ISSUE, EXTRACT and PRESENT.
REQ-023 EXTRACT: byte select 0->[7:0], 1->[15:8], 2->[23:16], 3->[31:24]. Sample = {byte', 8'h00}, where byte' = byte if SIGNED_SAMPLES=1, else byte with bit 7 inverted. Register it to sample_data, go to PRESENT.
REQ-024 PRESENT: sample_valid=1; sample_data held stable until the transfer cycle. After the transfer, go to IDLE and sample_valid=0 the next cycle.
REQ-025 start outside IDLE is ignored, with no queuing.
REQ-026 Latency from start to the first cycle of sample_valid: hit = 2 cycles. Miss = 3 + W + D cycles, where W = waitrequest stall cycles and D = cycles from acceptance to readdatavalid.
REQ-027 Only one read is outstanding at a time; flash_mem_read is never asserted outside ISSUE.
REQ-028 A change on word_addr or byte_sel after the start cycle has no effect on the sample in flight.

Reset
REQ-029 reset has priority over all inputs, in any state. Next cycle: state=IDLE, flash_mem_read=0, flash_mem_address=0, sample_valid=0, sample_data=0, busy=0, cache_valid=0.
REQ-030 Reset in ISSUE or WAIT_DATA abandons the read. A readdatavalid arriving after reset is discarded and does not load the cache.
REQ-031 start is ignored in any cycle where reset=1.

Verification
REQ-032 Miss, no stall: start, word_addr=0x000010, byte_sel=2; readdatavalid one cycle after acceptance with readdata=0xA1B2C3D4 -> read is a single cycle, sample_data=0xB200, sample_valid on the 4th cycle after start.
REQ-033 Stall: waitrequest=1 for 3 cycles -> read and address stable for 4 cycles, one acceptance, sample_valid on the 7th cycle after start.
REQ-034 Hit: after REQ-032, start word_addr=0x000010, byte_sel=0 -> no read, sample_data=0xD400, sample_valid 2 cycles after start.
REQ-035 Backpressure: sample_ready=0 for 5 cycles, and start pulses during PRESENT -> sample_data constant, starts ignored, exactly one transfer.
REQ-036 Reset in WAIT_DATA, then readdatavalid=1 next cycle -> IDLE, no sample_valid. A following start to the same address issues a fresh read (cache invalid).
REQ-037 SIGNED_SAMPLES=0, byte 0x80 -> sample_data=0x0000; byte 0x00 -> 0x8000.
